throw_ballistics: RTL and testbench

Projectile stage directly downstream of the local turn FSM. Measures how long the throw key is held while `enable_draw` is high and converts that into a saturating power value. On `throw_enable` it launches a projectile with velocities derived from that power, then steps it under gravity at a fixed motion rate. It reports position for the sprite renderer and a one-cycle hit or miss result for the game logic.

---
 rtl/throw_ballistics.sv | 201 ++++++++++++++++++++
 tb/tb_throw_ballistics.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/throw_ballistics.sv
// throw_ballistics: charges a power value while the throw key is held, then
// launches and steps a projectile under gravity until it hits the target,
// falls to the ground or leaves the screen. All outputs are registered.
module throw_ballistics #(
    parameter int unsigned CHARGE_CYCLES = 1_000_000,
    parameter int unsigned MAX_POWER     = 63,
    parameter int unsigned STEP_CYCLES   = 1_083_333,
    parameter int unsigned START_X       = 100,
    parameter int unsigned START_Y       = 500,
    parameter int unsigned GROUND_Y      = 700,
    parameter int unsigned SCREEN_W      = 1024,
    parameter int unsigned TARGET_W      = 64,
    parameter int unsigned GRAVITY       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_draw,
    input  logic        throw_enable,
    input  logic [10:0] target_x,
    input  logic [9:0]  target_y,
    output logic [5:0]  power,
    output logic [10:0] proj_x,
    output logic [9:0]  proj_y,
    output logic        proj_active,
    output logic        hit,
    output logic        miss
);

    localparam int CCW = $clog2(CHARGE_CYCLES + 1);
    localparam int SCW = $clog2(STEP_CYCLES + 1);
    localparam logic signed [13:0] GROUND_S = 14'(GROUND_Y);
    localparam logic signed [13:0] SCREEN_S = 14'(SCREEN_W);

    typedef enum logic [2:0] {IDLE, CHARGE, ARMED, FLIGHT, RESULT} state_t;

    state_t             state_q, state_d;
    logic [5:0]         power_q, power_d;
    logic [CCW-1:0]     charge_cnt_q, charge_cnt_d;
    logic [SCW-1:0]     step_cnt_q, step_cnt_d;
    logic signed [11:0] x_q, x_d, y_q, y_d;
    logic [4:0]         vx_q, vx_d;
    logic signed [7:0]  vy_q, vy_d;
    logic [10:0]        proj_x_q, proj_x_d;
    logic [9:0]         proj_y_q, proj_y_d;
    logic               proj_active_q, proj_active_d;
    logic               hit_q, hit_d, miss_q, miss_d;

    logic signed [11:0] x_step, y_step;
    logic signed [7:0]  vy_step;
    logic signed [13:0] xs, ys, tx_lo, tx_hi, ty;
    logic               step_hit, step_miss;
    logic [10:0]        step_x_out;
    logic [9:0]         step_y_out;

    // Candidate motion step and its position checks, widened so target
    // bounds near the top of the 11-bit range compare correctly.
    always_comb begin
        x_step     = x_q + {7'b0, vx_q};
        y_step     = y_q + {{4{vy_q[7]}}, vy_q};
        vy_step    = vy_q + 8'(GRAVITY);
        xs         = {{2{x_step[11]}}, x_step};
        ys         = {{2{y_step[11]}}, y_step};
        tx_lo      = {3'b0, target_x};
        tx_hi      = tx_lo + 14'(TARGET_W);
        ty         = {4'b0, target_y};
        step_hit   = (xs >= tx_lo) && (xs < tx_hi) && (ys >= ty);
        step_miss  = (ys >= GROUND_S) || (xs >= SCREEN_S);
        step_x_out = (xs >= SCREEN_S) ? 11'(SCREEN_W - 1) : x_step[10:0];
        if (ys[13]) begin
            step_y_out = '0;
        end else if (ys >= GROUND_S) begin
            step_y_out = 10'(GROUND_Y);
        end else begin
            step_y_out = y_step[9:0];
        end
    end

    // Next-state and registered-output logic for the shot sequence.
    always_comb begin
        state_d       = state_q;
        power_d       = power_q;
        charge_cnt_d  = charge_cnt_q;
        step_cnt_d    = step_cnt_q;
        x_d           = x_q;
        y_d           = y_q;
        vx_d          = vx_q;
        vy_d          = vy_q;
        proj_x_d      = proj_x_q;
        proj_y_d      = proj_y_q;
        proj_active_d = 1'b0;
        hit_d         = 1'b0;
        miss_d        = 1'b0;
        case (state_q)
            IDLE: begin
                proj_x_d = 11'(START_X);
                proj_y_d = 10'(START_Y);
                if (enable_draw) begin
                    state_d      = CHARGE;
                    power_d      = '0;
                    charge_cnt_d = '0;
                end
            end
            CHARGE: begin
                if (!enable_draw) begin
                    state_d = ARMED;
                end else if (charge_cnt_q == CCW'(CHARGE_CYCLES - 1)) begin
                    charge_cnt_d = '0;
                    power_d      = (power_q >= 6'(MAX_POWER)) ? 6'(MAX_POWER) : power_q + 6'd1;
                end else begin
                    charge_cnt_d = charge_cnt_q + CCW'(1);
                end
            end
            ARMED: begin
                if (throw_enable) begin
                    state_d       = FLIGHT;
                    vx_d          = {1'b0, power_q[5:2]} + 5'd1;
                    vy_d          = 8'd0 - {3'b0, power_q[5:1]};
                    x_d           = 12'(START_X);
                    y_d           = 12'(START_Y);
                    step_cnt_d    = '0;
                    proj_active_d = 1'b1;
                end else if (enable_draw) begin
                    state_d      = CHARGE;
                    power_d      = '0;
                    charge_cnt_d = '0;
                end
            end
            FLIGHT: begin
                proj_active_d = 1'b1;
                if (step_cnt_q == SCW'(STEP_CYCLES - 1)) begin
                    step_cnt_d = '0;
                    x_d        = x_step;
                    y_d        = y_step;
                    vy_d       = vy_step;
                    proj_x_d   = step_x_out;
                    proj_y_d   = step_y_out;
                    if (step_hit) begin
                        state_d       = RESULT;
                        hit_d         = 1'b1;
                        proj_active_d = 1'b0;
                    end else if (step_miss) begin
                        state_d       = RESULT;
                        miss_d        = 1'b1;
                        proj_active_d = 1'b0;
                    end
                end else begin
                    step_cnt_d = step_cnt_q + SCW'(1);
                end
            end
            RESULT: begin
                // Final position is visible during RESULT; load the launch
                // point now so it appears together with IDLE.
                state_d  = IDLE;
                proj_x_d = 11'(START_X);
                proj_y_d = 10'(START_Y);
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            power_q       <= '0;
            charge_cnt_q  <= '0;
            step_cnt_q    <= '0;
            x_q           <= 12'(START_X);
            y_q           <= 12'(START_Y);
            vx_q          <= '0;
            vy_q          <= '0;
            proj_x_q      <= 11'(START_X);
            proj_y_q      <= 10'(START_Y);
            proj_active_q <= 1'b0;
            hit_q         <= 1'b0;
            miss_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            power_q       <= power_d;
            charge_cnt_q  <= charge_cnt_d;
            step_cnt_q    <= step_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            vx_q          <= vx_d;
            vy_q          <= vy_d;
            proj_x_q      <= proj_x_d;
            proj_y_q      <= proj_y_d;
            proj_active_q <= proj_active_d;
            hit_q         <= hit_d;
            miss_q        <= miss_d;
        end
    end

    assign power       = power_q;
    assign proj_x      = proj_x_q;
    assign proj_y      = proj_y_q;
    assign proj_active = proj_active_q;
    assign hit         = hit_q;
    assign miss        = miss_q;

endmodule

// File: tb/tb_throw_ballistics.sv
// Bench for throw_ballistics with CHARGE_CYCLES=4, STEP_CYCLES=2, TARGET_W=8.
module tb_throw_ballistics;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_draw;
    logic        throw_enable;
    logic [10:0] target_x;
    logic [9:0]  target_y;
    logic [5:0]  power;
    logic [10:0] proj_x;
    logic [9:0]  proj_y;
    logic        proj_active;
    logic        hit;
    logic        miss;

    int n_checks = 0;
    int n_fail   = 0;
    int qx[$];
    int qy[$];

    throw_ballistics #(
        .CHARGE_CYCLES(4),
        .STEP_CYCLES  (2),
        .TARGET_W     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable_draw (enable_draw),
        .throw_enable(throw_enable),
        .target_x    (target_x),
        .target_y    (target_y),
        .power       (power),
        .proj_x      (proj_x),
        .proj_y      (proj_y),
        .proj_active (proj_active),
        .hit         (hit),
        .miss        (miss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference trajectory: plain integer kinematics, positions as the
    // renderer should see them after each step.
    task automatic model_shot(input int p, input int tx, input int ty,
                              output int n, output bit is_hit);
        int x, y, vx, vy;
        x = 100; y = 500; vx = p / 4 + 1; vy = -(p / 2);
        n = 0; is_hit = 1'b0;
        qx.delete(); qy.delete();
        for (int k = 0; k < 500; k++) begin
            x += vx; y += vy; vy += 1; n++;
            qx.push_back(x >= 1024 ? 1023 : x);
            qy.push_back(y < 0 ? 0 : (y >= 700 ? 700 : y));
            if (x >= tx && x < tx + 8 && y >= ty) begin
                is_hit = 1'b1;
                break;
            end
            if (y >= 700 || x >= 1024) break;
        end
    endtask

    task automatic run_shot(input int n_hold, input int tx, input int ty, input bit disturb,
                            output int gpw, output int gx1, output int gy1,
                            output int gfx, output int gfy, output bit ghit);
        int p, nsteps, act_cnt, k;
        bit mh;
        gx1 = 0; gy1 = 0; gfx = 0; gfy = 0; ghit = 1'b0;
        target_x = 11'(tx);
        target_y = 10'(ty);
        enable_draw = 1'b1;
        repeat (n_hold) @(posedge clk);
        #1 enable_draw = 1'b0;
        @(posedge clk); #1;
        p = (n_hold - 1) / 4;
        if (p > 63) p = 63;
        gpw = power;
        chk("power_model", power, p);
        model_shot(p, tx, ty, nsteps, mh);
        throw_enable = 1'b1;
        @(posedge clk); #1 throw_enable = 1'b0;
        chk("launch_active", proj_active, 1);
        chk("launch_x", proj_x, 100);
        chk("launch_y", proj_y, 500);
        act_cnt = 1;
        for (int cyc = 1; cyc <= 2 * nsteps; cyc++) begin
            if (disturb) begin
                enable_draw  = 1'($urandom);
                throw_enable = 1'($urandom);
            end
            @(posedge clk); #1;
            if (cyc == 2 * nsteps) begin
                enable_draw  = 1'b0;
                throw_enable = 1'b0;
            end
            if (proj_active) act_cnt++;
            if (cyc % 2 == 0) begin
                k = cyc / 2;
                chk("step_x", proj_x, qx[k-1]);
                chk("step_y", proj_y, qy[k-1]);
                if (k == 1) begin gx1 = proj_x; gy1 = proj_y; end
                if (k == nsteps) begin
                    gfx = proj_x; gfy = proj_y; ghit = hit;
                    chk("result_hit", hit, int'(mh));
                    chk("result_miss", miss, int'(!mh));
                    chk("result_active", proj_active, 0);
                end else begin
                    chk("no_early_pulse", {hit, miss}, 0);
                end
            end
        end
        chk("active_cycles", act_cnt, 2 * nsteps);
        @(posedge clk); #1;
        chk("idle_pulse", {hit, miss}, 0);
        chk("idle_x", proj_x, 100);
        chk("idle_y", proj_y, 500);
        chk("idle_power_hold", power, p);
    endtask

    typedef struct {
        int n_hold; int tx; int ty;
        int pw; int x1; int y1; int fx; int fy;
        bit hit; bit disturb;
    } shot_t;

    shot_t tbl[9];

    initial begin
        int gpw, gx1, gy1, gfx, gfy;
        bit ghit;

        tbl[0] = '{33,  109,  480, 8,  103, 496, 109, 491, 1'b1, 1'b0};
        tbl[1] = '{33,  900,  480, 8,  103, 496, 175, 700, 1'b0, 1'b0};
        tbl[2] = '{400, 900,  0,   63, 116, 469, 900, 175, 1'b1, 1'b0};
        tbl[3] = '{1,   900,  480, 0,  101, 500, 121, 700, 1'b0, 1'b0};
        tbl[4] = '{4,   900,  480, 0,  101, 500, 121, 700, 1'b0, 1'b0};
        tbl[5] = '{5,   900,  480, 1,  101, 500, 121, 700, 1'b0, 1'b0};
        tbl[6] = '{252, 1000, 0,   62, 116, 469, 1023, 355, 1'b0, 1'b0};
        tbl[7] = '{1,   118,  705, 0,  101, 500, 121, 700, 1'b1, 1'b0};
        tbl[8] = '{33,  109,  480, 8,  103, 496, 109, 491, 1'b1, 1'b1};

        rst = 1'b1; enable_draw = 1'b0; throw_enable = 1'b0;
        target_x = 11'd0; target_y = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_power", power, 0);
        chk("rst_x", proj_x, 100);
        chk("rst_y", proj_y, 500);
        chk("rst_active", proj_active, 0);
        chk("rst_pulses", {hit, miss}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            run_shot(tbl[i].n_hold, tbl[i].tx, tbl[i].ty, tbl[i].disturb,
                     gpw, gx1, gy1, gfx, gfy, ghit);
            chk($sformatf("tbl%0d_power", i), gpw, tbl[i].pw);
            chk($sformatf("tbl%0d_x1", i), gx1, tbl[i].x1);
            chk($sformatf("tbl%0d_y1", i), gy1, tbl[i].y1);
            chk($sformatf("tbl%0d_fx", i), gfx, tbl[i].fx);
            chk($sformatf("tbl%0d_fy", i), gfy, tbl[i].fy);
            chk($sformatf("tbl%0d_hit", i), ghit, tbl[i].hit);
        end

        // Recharge from ARMED restarts power at zero.
        enable_draw = 1'b1;
        repeat (21) @(posedge clk);
        #1 enable_draw = 1'b0;
        @(posedge clk); #1;
        chk("recharge_first", power, 5);
        enable_draw = 1'b1;
        @(posedge clk); #1;
        chk("recharge_restart", power, 0);
        repeat (8) @(posedge clk);
        #1 enable_draw = 1'b0;
        @(posedge clk); #1;
        chk("recharge_second", power, 2);

        // Launch from ARMED, then reset mid-flight.
        target_x = 11'd900; target_y = 10'd480;
        throw_enable = 1'b1;
        @(posedge clk); #1 throw_enable = 1'b0;
        chk("abort_launch_active", proj_active, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_active", proj_active, 0);
        chk("abort_x", proj_x, 100);
        chk("abort_y", proj_y, 500);
        chk("abort_power", power, 0);
        chk("abort_pulses", {hit, miss}, 0);
        begin
            int pulses;
            pulses = 0;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk); #1;
                if (hit || miss || proj_active) pulses++;
            end
            chk("abort_quiet", pulses, 0);
        end

        // Randomised shots against the reference model.
        for (int r = 0; r < 8; r++) begin
            run_shot(int'($urandom_range(1, 300)), int'($urandom_range(100, 1000)),
                     int'($urandom_range(300, 700)), 1'($urandom),
                     gpw, gx1, gy1, gfx, gfy, ghit);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
